// File: rtl/vec_chunk_server.sv
// rtl/vec_chunk_server.sv - buffers one chunked vector and replays it NumPasses times on request.
// Optional ping-pong buffering is enabled with `define VCS_DOUBLE_BUFFER_EN.
module vec_chunk_server #(
    parameter int VecLength   = 12,
    parameter int WorkingRegs = 3,
    parameter int NumPasses   = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        wr_valid,
    input  logic [WorkingRegs-1:0][7:0] wr_data,
    output logic                        wr_ready,
    input  logic                        req_chunk_in,
    output logic [WorkingRegs-1:0][7:0] out_data,
    output logic                        out_data_ready,
    output logic                        vec_done,
    output logic                        req_err
);

    localparam int NCH = VecLength / WorkingRegs;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = (NumPasses > 1) ? $clog2(NumPasses) : 1;
    localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(NumPasses - 1);
`ifdef VCS_DOUBLE_BUFFER_EN
    localparam int NB = 2;
    localparam int AW = CW + 1;
`else
    localparam int NB = 1;
    localparam int AW = CW;
`endif

    typedef enum logic {ST_FILL, ST_SERVE} state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [CW-1:0]                 r_wr_idx;
    logic [CW-1:0]                 r_rd_idx;
    logic [PW-1:0]                 r_pass_idx;
    logic [WorkingRegs-1:0][7:0]   r_buf [NB*NCH];

    logic          w_wr_fire;
    logic          w_wr_last;
    logic          w_serve;
    logic          w_vec_last;
    logic          w_swap;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

`ifdef VCS_DOUBLE_BUFFER_EN
    // r_fbank is the bank being filled; the other bank is the one being served.
    logic r_fbank;
    logic r_f_full;
    assign w_waddr = {r_fbank, r_wr_idx};
    assign w_raddr = {~r_fbank, r_rd_idx};
    assign w_swap  = w_vec_last && (r_f_full || w_wr_last);
`else
    assign w_waddr = r_wr_idx;
    assign w_raddr = r_rd_idx;
    assign w_swap  = 1'b0;
`endif

    assign w_wr_fire  = wr_valid && wr_ready;
    assign w_wr_last  = w_wr_fire && (r_wr_idx == LAST_CH);
    assign w_serve    = req_chunk_in && (r_state == ST_SERVE);
    assign w_vec_last = w_serve && (r_rd_idx == LAST_CH) && (r_pass_idx == LAST_PASS);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FILL:  if (w_wr_last) w_next_state = ST_SERVE;
            ST_SERVE: if (w_vec_last && !w_swap) w_next_state = ST_FILL;
            default:  w_next_state = ST_FILL;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
`ifdef VCS_DOUBLE_BUFFER_EN
        wr_ready = (r_state == ST_FILL) || !r_f_full;
`else
        wr_ready = (r_state == ST_FILL);
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_idx       <= '0;
            r_rd_idx       <= '0;
            r_pass_idx     <= '0;
            out_data       <= '0;
            out_data_ready <= 1'b0;
            vec_done       <= 1'b0;
            req_err        <= 1'b0;
        end else begin
            out_data_ready <= w_serve;
            vec_done       <= w_vec_last;
            if (w_serve) begin
                out_data <= r_buf[w_raddr];
            end
            if (req_chunk_in && (r_state == ST_FILL)) begin
                req_err <= 1'b1;
            end
            if (w_wr_fire) begin
                r_wr_idx <= (r_wr_idx == LAST_CH) ? '0 : r_wr_idx + 1'b1;
            end
            if (w_serve) begin
                if (r_rd_idx == LAST_CH) begin
                    r_rd_idx   <= '0;
                    r_pass_idx <= (r_pass_idx == LAST_PASS) ? '0 : r_pass_idx + 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

`ifdef VCS_DOUBLE_BUFFER_EN
    // A fill completing while idle hands the bank straight to the server; during
    // SERVE it parks as full until the current vector's last chunk goes out.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fbank  <= 1'b0;
            r_f_full <= 1'b0;
        end else if ((r_state == ST_FILL) && w_wr_last) begin
            r_fbank <= ~r_fbank;
        end else if (w_swap) begin
            r_fbank  <= ~r_fbank;
            r_f_full <= 1'b0;
        end else if ((r_state == ST_SERVE) && w_wr_last) begin
            r_f_full <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (w_wr_fire) begin
            r_buf[w_waddr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_vec_chunk_server.sv
// tb/tb_vec_chunk_server.sv - directed self-checking bench for vec_chunk_server.
module tb_vec_chunk_server;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            wr_valid;
    logic [2:0][7:0] wr_data;
    logic            wr_ready;
    logic            req_chunk_in;
    logic [2:0][7:0] out_data;
    logic            out_data_ready;
    logic            vec_done;
    logic            req_err;

    int n_cmp = 0;
    int n_bad = 0;

    vec_chunk_server #(.VecLength(12), .WorkingRegs(3), .NumPasses(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .req_chunk_in   (req_chunk_in),
        .out_data       (out_data),
        .out_data_ready (out_data_ready),
        .vec_done       (vec_done),
        .req_err        (req_err)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [2:0][7:0] mk(input int c, input bit neg);
        logic [2:0][7:0] r;
        for (int j = 0; j < 3; j++) begin
            int v;
            v = 3 * c + j + 1;
            r[j] = neg ? 8'(-v) : 8'(v);
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        rst_in       = 1'b1;
        wr_valid     = 1'b0;
        req_chunk_in = 1'b0;
        wr_data      = '0;
        tick;
        tick;
        rst_in = 1'b0;
    endtask

    task automatic write_vec(input bit neg);
        for (int c = 0; c < 4; c++) begin
            wr_valid = 1'b1;
            wr_data  = mk(c, neg);
            tick;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        n_cmp++; if (out_data !== 24'h0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 000000", out_data); end
        n_cmp++; if (out_data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_out_ready: got %b expected 0", out_data_ready); end
        n_cmp++; if (vec_done !== 1'b0) begin n_bad++; $display("FAIL reset_vec_done: got %b expected 0", vec_done); end
        n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL reset_req_err: got %b expected 0", req_err); end
    endtask

    task automatic test_serve_pulses;
        do_reset;
        write_vec(1'b0);
        for (int k = 0; k < 16; k++) begin
            req_chunk_in = 1'b1;
            tick;
            req_chunk_in = 1'b0;
            n_cmp++;
            if (out_data_ready !== 1'b1 || out_data !== mk(k % 4, 1'b0)) begin
                n_bad++; $display("FAIL pulse_chunk%0d: got rdy=%b data=%h expected rdy=1 data=%h", k, out_data_ready, out_data, mk(k % 4, 1'b0));
            end
            n_cmp++;
            if (vec_done !== logic'(k == 15)) begin
                n_bad++; $display("FAIL pulse_done%0d: got %b expected %b", k, vec_done, k == 15);
            end
            tick;
            n_cmp++;
            if (out_data_ready !== 1'b0 || out_data !== mk(k % 4, 1'b0)) begin
                n_bad++; $display("FAIL pulse_hold%0d: got rdy=%b data=%h expected rdy=0 data=%h", k, out_data_ready, out_data, mk(k % 4, 1'b0));
            end
        end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL pulse_refill_ready: got %b expected 1", wr_ready); end
        n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL pulse_req_err: got %b expected 0", req_err); end
    endtask

    task automatic test_back_to_back;
        int n_done;
        n_done = 0;
        do_reset;
        write_vec(1'b0);
        req_chunk_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick;
            if (k == 15) req_chunk_in = 1'b0;
            if (vec_done === 1'b1) n_done++;
            n_cmp++;
            if (out_data_ready !== 1'b1 || out_data !== mk(k % 4, 1'b0)) begin
                n_bad++; $display("FAIL b2b_chunk%0d: got rdy=%b data=%h expected rdy=1 data=%h", k, out_data_ready, out_data, mk(k % 4, 1'b0));
            end
        end
        n_cmp++; if (vec_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_last: got %b expected 1", vec_done); end
        tick;
        n_cmp++; if (out_data_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_after: got %b expected 0", out_data_ready); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 1", n_done); end
        n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL b2b_req_err: got %b expected 0", req_err); end
    endtask

    task automatic test_req_in_fill;
        do_reset;
        for (int c = 0; c < 2; c++) begin
            wr_valid = 1'b1;
            wr_data  = mk(c, 1'b0);
            tick;
        end
        wr_valid     = 1'b0;
        req_chunk_in = 1'b1;
        tick;
        req_chunk_in = 1'b0;
        n_cmp++; if (out_data_ready !== 1'b0) begin n_bad++; $display("FAIL fill_req_rdy: got %b expected 0", out_data_ready); end
        n_cmp++; if (req_err !== 1'b1) begin n_bad++; $display("FAIL fill_req_err: got %b expected 1", req_err); end
        for (int c = 2; c < 4; c++) begin
            wr_valid = 1'b1;
            wr_data  = mk(c, 1'b0);
            tick;
        end
        wr_valid = 1'b0;
        tick;
        n_cmp++; if (req_err !== 1'b1) begin n_bad++; $display("FAIL fill_req_err_sticky: got %b expected 1", req_err); end
        do_reset;
        n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL fill_req_err_cleared: got %b expected 0", req_err); end
    endtask

    task automatic test_reset_abort;
        int n_done;
        n_done = 0;
        do_reset;
        write_vec(1'b0);
        for (int k = 0; k < 6; k++) begin
            req_chunk_in = 1'b1;
            tick;
            req_chunk_in = 1'b0;
            if (vec_done === 1'b1) n_done++;
            tick;
        end
        rst_in = 1'b1;
        tick;
        if (vec_done === 1'b1) n_done++;
        rst_in = 1'b0;
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL abort_wr_ready: got %b expected 1", wr_ready); end
        write_vec(1'b1);
        req_chunk_in = 1'b1;
        tick;
        req_chunk_in = 1'b0;
        if (vec_done === 1'b1) n_done++;
        n_cmp++;
        if (out_data_ready !== 1'b1 || out_data !== mk(0, 1'b1)) begin
            n_bad++; $display("FAIL abort_first_chunk: got rdy=%b data=%h expected rdy=1 data=%h", out_data_ready, out_data, mk(0, 1'b1));
        end
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
    endtask

`ifndef VCS_DOUBLE_BUFFER_EN
    task automatic test_wr_in_serve;
        do_reset;
        write_vec(1'b0);
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL serve_wr_ready: got %b expected 0", wr_ready); end
        wr_valid = 1'b1;
        wr_data  = 24'h636363;
        tick;
        tick;
        wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_chunk_in = 1'b1;
            tick;
            req_chunk_in = 1'b0;
            n_cmp++;
            if (out_data_ready !== 1'b1 || out_data !== mk(k, 1'b0)) begin
                n_bad++; $display("FAIL serve_wr_chunk%0d: got rdy=%b data=%h expected rdy=1 data=%h", k, out_data_ready, out_data, mk(k, 1'b0));
            end
        end
    endtask
`else
    task automatic test_double_buffer;
        do_reset;
        write_vec(1'b0);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL dbl_wr_ready_serve: got %b expected 1", wr_ready); end
        req_chunk_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wr_valid = (k < 4);
            wr_data  = mk(k % 4, 1'b1);
            tick;
            n_cmp++;
            if (out_data_ready !== 1'b1 || out_data !== mk(k % 4, 1'b0)) begin
                n_bad++; $display("FAIL dbl_a_chunk%0d: got rdy=%b data=%h expected rdy=1 data=%h", k, out_data_ready, out_data, mk(k % 4, 1'b0));
            end
            if (k == 4) begin
                n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL dbl_wr_ready_full: got %b expected 0", wr_ready); end
            end
        end
        wr_valid = 1'b0;
        n_cmp++; if (vec_done !== 1'b1) begin n_bad++; $display("FAIL dbl_a_done: got %b expected 1", vec_done); end
        tick;
        req_chunk_in = 1'b0;
        n_cmp++;
        if (out_data_ready !== 1'b1 || out_data !== mk(0, 1'b1)) begin
            n_bad++; $display("FAIL dbl_b_chunk0: got rdy=%b data=%h expected rdy=1 data=%h", out_data_ready, out_data, mk(0, 1'b1));
        end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL dbl_wr_ready_swap: got %b expected 1", wr_ready); end
        n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL dbl_req_err: got %b expected 0", req_err); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_serve_pulses;
        test_back_to_back;
        test_req_in_fill;
        test_reset_abort;
`ifndef VCS_DOUBLE_BUFFER_EN
        test_wr_in_serve;
`else
        test_double_buffer;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
